axi_lite_wdata_fifo: RTL and testbench

- Parametrised AXI4-Lite write-data (W) channel stage between a master-side W interface and a slave-side W interface.
- Buffers up to DEPTH beats with full VALID/READY handshakes on both sides.
- Applies byte-strobe masking and optionally drops null-strobe beats.
- Generalises the fixed 32-bit combinational write-data path to any byte-multiple width, with real buffering and back-pressure.

---
 rtl/axi_lite_wdata_fifo.sv | 105 ++++++++++
 tb/tb_axi_lite_wdata_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_wdata_fifo.sv
// AXI4-Lite W-channel buffer: DEPTH-entry FIFO with byte-strobe masking and optional null-beat dropping.
// Ready is registered from occupancy only, so there is no m_WREADY -> s_WREADY path.
module axi_lite_wdata_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MASK_DATA  = 1,
    parameter int DROP_NULL  = 0
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      s_WVALID,
    output logic                      s_WREADY,
    input  logic [DATA_WIDTH-1:0]     s_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   s_WSTRB,
    output logic                      m_WVALID,
    input  logic                      m_WREADY,
    output logic [DATA_WIDTH-1:0]     m_WDATA,
    output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
    output logic [$clog2(DEPTH):0]    level,
    output logic [7:0]                null_cnt
);
    localparam int   STRB_W = DATA_WIDTH / 8;
    localparam int   AW     = $clog2(DEPTH);
    localparam int   LW     = AW + 1;
    localparam logic MASK   = (MASK_DATA != 0);
    localparam logic DROP   = (DROP_NULL != 0);

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [STRB_W-1:0]     mem_strb [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         level_next;
    logic                  ready_q;
    logic [7:0]            null_q;
    logic [DATA_WIDTH-1:0] wdata_masked;
    logic                  push;
    logic                  pop;
    logic                  is_null;
    logic                  store;
    logic                  count_null;

    assign push       = s_WVALID && ready_q;
    assign is_null    = (s_WSTRB == '0);
    assign store      = push && !(DROP && is_null);
    assign count_null = push && DROP && is_null;
    assign pop        = (level_q != '0) && m_WREADY;

    always_comb begin
        wdata_masked = s_WDATA;
        for (int i = 0; i < STRB_W; i++) begin
            if (MASK && !s_WSTRB[i]) begin
                wdata_masked[8*i +: 8] = 8'h00;
            end
        end
    end

    always_comb begin
        level_next = level_q;
        case ({store, pop})
            2'b10:   level_next = level_q + LW'(1);
            2'b01:   level_next = level_q - LW'(1);
            default: level_next = level_q;
        endcase
    end

    // Storage is not reset: empty entries are never visible because outputs are gated by level.
    always_ff @(posedge ACLK) begin
        if (store) begin
            mem_data[wr_ptr] <= wdata_masked;
            mem_strb[wr_ptr] <= s_WSTRB;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
            null_q  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level_q <= level_next;
            // A pop while full frees a slot for the following cycle, not this one.
            ready_q <= (level_next != LW'(DEPTH));
            if (count_null && (null_q != 8'hFF)) begin
                null_q <= null_q + 8'd1;
            end
        end
    end

    assign s_WREADY = ready_q;
    assign m_WVALID = (level_q != '0);
    assign m_WDATA  = m_WVALID ? mem_data[rd_ptr] : '0;
    assign m_WSTRB  = m_WVALID ? mem_strb[rd_ptr] : '0;
    assign level    = level_q;
    assign null_cnt = null_q;

endmodule

// File: tb/tb_axi_lite_wdata_fifo.sv
// Directed bench for axi_lite_wdata_fifo: a default instance (masking, no drop) and a
// drop-null instance without masking, checked against hand-computed values.
module tb_axi_lite_wdata_fifo;
    logic        ACLK;
    logic        ARESETn;

    logic        s_WVALID, s_WREADY, m_WVALID, m_WREADY;
    logic [31:0] s_WDATA, m_WDATA;
    logic [3:0]  s_WSTRB, m_WSTRB;
    logic [2:0]  level;
    logic [7:0]  null_cnt;

    logic        d_s_WVALID, d_s_WREADY, d_m_WVALID, d_m_WREADY;
    logic [31:0] d_s_WDATA, d_m_WDATA;
    logic [3:0]  d_s_WSTRB, d_m_WSTRB;
    logic [2:0]  d_level;
    logic [7:0]  d_null_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    axi_lite_wdata_fifo #(.DATA_WIDTH(32), .DEPTH(4), .MASK_DATA(1), .DROP_NULL(0)) u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
        .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
        .level(level), .null_cnt(null_cnt)
    );

    axi_lite_wdata_fifo #(.DATA_WIDTH(32), .DEPTH(4), .MASK_DATA(0), .DROP_NULL(1)) u_drop (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_WVALID(d_s_WVALID), .s_WREADY(d_s_WREADY), .s_WDATA(d_s_WDATA), .s_WSTRB(d_s_WSTRB),
        .m_WVALID(d_m_WVALID), .m_WREADY(d_m_WREADY), .m_WDATA(d_m_WDATA), .m_WSTRB(d_m_WSTRB),
        .level(d_level), .null_cnt(d_null_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {b ^ 8'h5A, b, 8'hA5, ~b};
    endfunction

    function automatic logic [3:0] beat_strb(input int n);
        return n[3:0];
    endfunction

    function automatic logic [31:0] mask32(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (!s[i]) r[8*i +: 8] = 8'h00;
        end
        return r;
    endfunction

    int          push_n, pop_n, lvl_m, cyc;
    logic        pv, pp, stall;
    logic [31:0] hold_d;
    logic [3:0]  hold_s;

    initial begin
        ARESETn = 1'b0;
        s_WVALID = 1'b0; s_WDATA = '0; s_WSTRB = '0; m_WREADY = 1'b0;
        d_s_WVALID = 1'b0; d_s_WDATA = '0; d_s_WSTRB = '0; d_m_WREADY = 1'b0;

        // Reset values
        tick; tick;
        chk("rst_wready", 64'(s_WREADY), 64'(0));
        chk("rst_wvalid", 64'(m_WVALID), 64'(0));
        chk("rst_level",  64'(level),    64'(0));
        chk("rst_wdata",  64'(m_WDATA),  64'(0));
        chk("rst_null",   64'(null_cnt), 64'(0));
        ARESETn = 1'b1;
        #1;
        chk("rel_wready_pre", 64'(s_WREADY), 64'(0));
        tick;
        chk("rel_wready", 64'(s_WREADY), 64'(1));

        // Single masked beat
        s_WVALID = 1'b1; s_WDATA = 32'hDEADBEEF; s_WSTRB = 4'b0101;
        tick;
        s_WVALID = 1'b0;
        chk("t1_valid", 64'(m_WVALID), 64'(1));
        chk("t1_data",  64'(m_WDATA),  64'h00AD00EF);
        chk("t1_strb",  64'(m_WSTRB),  64'(4'b0101));
        chk("t1_level", 64'(level),    64'(1));
        m_WREADY = 1'b1;
        tick;
        m_WREADY = 1'b0;
        chk("t1_pop_level", 64'(level),    64'(0));
        chk("t1_pop_valid", 64'(m_WVALID), 64'(0));
        chk("t1_pop_data",  64'(m_WDATA),  64'(0));

        // Null strobe is stored when drop is disabled
        s_WVALID = 1'b1; s_WDATA = 32'hFFFFFFFF; s_WSTRB = 4'h0;
        tick;
        s_WVALID = 1'b0;
        chk("nul_keep_level", 64'(level),    64'(1));
        chk("nul_keep_valid", 64'(m_WVALID), 64'(1));
        chk("nul_keep_data",  64'(m_WDATA),  64'(0));
        chk("nul_keep_cnt",   64'(null_cnt), 64'(0));
        m_WREADY = 1'b1;
        tick;
        m_WREADY = 1'b0;
        chk("nul_keep_drain", 64'(level), 64'(0));

        // Fill with back-pressure, then drain
        s_WSTRB = 4'hF;
        for (int i = 1; i <= 5; i++) begin
            s_WVALID = 1'b1; s_WDATA = 32'(i);
            tick;
        end
        chk("t2_full_level",  64'(level),    64'(4));
        chk("t2_full_wready", 64'(s_WREADY), 64'(0));
        chk("t2_head1",       64'(m_WDATA),  64'(1));
        m_WREADY = 1'b1;
        tick;
        chk("t2_pop1_level",  64'(level),    64'(3));
        chk("t2_pop1_wready", 64'(s_WREADY), 64'(1));
        chk("t2_head2",       64'(m_WDATA),  64'(2));
        tick;
        s_WVALID = 1'b0;
        chk("t2_pushpop_level", 64'(level),   64'(3));
        chk("t2_head3",         64'(m_WDATA), 64'(3));
        for (int j = 4; j <= 5; j++) begin
            tick;
            chk("t2_head_n", 64'(m_WDATA), 64'(j));
        end
        tick;
        chk("t2_empty", 64'(level), 64'(0));

        // Streaming, one beat per cycle
        m_WREADY = 1'b1; s_WVALID = 1'b1; s_WSTRB = 4'hF;
        for (int i = 0; i < 16; i++) begin
            s_WDATA = 32'(i);
            tick;
            chk("t3_data",  64'(m_WDATA), 64'(i));
            chk("t3_level", 64'(level),   64'(1));
        end
        s_WVALID = 1'b0;
        tick;
        chk("t3_drain", 64'(level), 64'(0));

        // Random back-pressure with in-order scoreboard
        push_n = 0; pop_n = 0; lvl_m = 0; cyc = 0;
        while ((push_n < 1000 || pop_n < 1000) && cyc < 20000) begin
            if (push_n < 1000) begin
                s_WVALID = ($urandom_range(0, 3) != 0);
                s_WDATA  = beat_data(push_n);
                s_WSTRB  = beat_strb(push_n);
            end else begin
                s_WVALID = 1'b0;
            end
            m_WREADY = ($urandom_range(0, 2) != 0);
            #1;
            pv = s_WVALID && s_WREADY;
            pp = m_WVALID && m_WREADY;
            stall = m_WVALID && !m_WREADY;
            hold_d = m_WDATA;
            hold_s = m_WSTRB;
            if (pp) begin
                chk("bp_data", 64'(hold_d), 64'(mask32(beat_data(pop_n), beat_strb(pop_n))));
                chk("bp_strb", 64'(hold_s), 64'(beat_strb(pop_n)));
                pop_n++;
                lvl_m--;
            end
            tick;
            cyc++;
            if (pv) begin
                push_n++;
                lvl_m++;
            end
            if (stall) begin
                chk("bp_hold_valid", 64'(m_WVALID), 64'(1));
                chk("bp_hold_data",  64'(m_WDATA),  64'(hold_d));
                chk("bp_hold_strb",  64'(m_WSTRB),  64'(hold_s));
            end
            chk("bp_level",  64'(level),    64'(lvl_m));
            chk("bp_wready", 64'(s_WREADY), 64'(lvl_m != 4));
        end
        s_WVALID = 1'b0; m_WREADY = 1'b0;
        chk("bp_pushed", 64'(push_n), 64'(1000));
        chk("bp_popped", 64'(pop_n),  64'(1000));

        // Null-beat dropping (unmasked instance)
        d_s_WVALID = 1'b1;
        d_s_WDATA = 32'h11111111; d_s_WSTRB = 4'hF; tick;
        d_s_WDATA = 32'h22222222; d_s_WSTRB = 4'h0; tick;
        d_s_WDATA = 32'h33333333; d_s_WSTRB = 4'h3; tick;
        d_s_WVALID = 1'b0;
        chk("t5_level", 64'(d_level),    64'(2));
        chk("t5_null",  64'(d_null_cnt), 64'(1));
        chk("t5_head1", 64'(d_m_WDATA),  64'h11111111);
        d_m_WREADY = 1'b1;
        tick;
        chk("t5_head2", 64'(d_m_WDATA), 64'h33333333);
        chk("t5_strb2", 64'(d_m_WSTRB), 64'(4'h3));
        tick;
        d_m_WREADY = 1'b0;
        chk("t5_empty", 64'(d_m_WVALID), 64'(0));
        d_s_WVALID = 1'b1; d_s_WSTRB = 4'h0;
        repeat (253) tick;
        chk("t5_null_254", 64'(d_null_cnt), 64'(254));
        tick;
        chk("t5_null_255", 64'(d_null_cnt), 64'(255));
        repeat (46) tick;
        d_s_WVALID = 1'b0;
        chk("t5_null_sat",    64'(d_null_cnt), 64'(255));
        chk("t5_null_level",  64'(d_level),    64'(0));
        chk("t5_null_wready", 64'(d_s_WREADY), 64'(1));

        // Asynchronous reset mid-cycle with three beats buffered
        m_WREADY = 1'b0; s_WVALID = 1'b1; s_WSTRB = 4'hF;
        s_WDATA = 32'hA1; tick;
        s_WDATA = 32'hA2; tick;
        s_WDATA = 32'hA3; tick;
        s_WVALID = 1'b0;
        chk("t6_pre_level", 64'(level), 64'(3));
        #2;
        ARESETn = 1'b0;
        #1;
        chk("t6_valid",  64'(m_WVALID),   64'(0));
        chk("t6_level",  64'(level),      64'(0));
        chk("t6_data",   64'(m_WDATA),    64'(0));
        chk("t6_wready", 64'(s_WREADY),   64'(0));
        chk("t6_null",   64'(d_null_cnt), 64'(0));
        tick;
        ARESETn = 1'b1;
        tick;
        chk("t6_rel_wready", 64'(s_WREADY), 64'(1));
        s_WVALID = 1'b1; s_WDATA = 32'hCAFEF00D; s_WSTRB = 4'hF;
        tick;
        s_WVALID = 1'b0;
        chk("t6_new_valid", 64'(m_WVALID), 64'(1));
        chk("t6_new_data",  64'(m_WDATA),  64'hCAFEF00D);
        chk("t6_new_level", 64'(level),    64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
